cpu_16bit_core: RTL and testbench

- Single-cycle 16-bit load/store CPU with internal instruction memory, data memory and an 8x16 register file.
- A host loads the program word by word through a load port; the core then executes from PC 0.
- The most recent register write-back value is exported on result_reg for observation.
- Top-level compute block; standalone, with no external memory bus.

---
 rtl/cpu_16bit_core_if.sv | 19 +
 rtl/cpu_16bit_core.sv | 117 +++++++++++
 tb/tb_cpu_16bit_core.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_16bit_core_if.sv
// Program-load port of cpu_16bit_core.
// The host (master) writes instruction words into the core's imem.
interface cpu_16bit_core_if;
  logic [15:0] instruction_in;
  logic [15:0] load_address;
  logic        load_instruction;

  modport master (
    output instruction_in,
    output load_address,
    output load_instruction
  );

  modport slave (
    input instruction_in,
    input load_address,
    input load_instruction
  );
endinterface

// File: rtl/cpu_16bit_core.sv
// Single-cycle 16-bit load/store CPU with internal imem/dmem and 8x16 regs.
// Optional CPU16_PC_OUT_EN exports pc_out and halted.
module cpu_16bit_core #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic            clk,
  input  logic            pc_reset,
  cpu_16bit_core_if.slave ld,
  output logic [15:0]     result_reg
`ifdef CPU16_PC_OUT_EN
  ,
  output logic [15:0]     pc_out,
  output logic            halted
`endif
);

  logic [15:0] r_imem [2**IMEM_AW];
  logic [15:0] r_dmem [2**DMEM_AW];
  logic [15:0] r_rf [8];
  logic [15:0] r_pc;
  logic [15:0] r_result;
  logic        r_halted;

  logic [15:0] w_ins;
  logic [3:0]  w_op;
  logic [2:0]  w_rd, w_rs, w_rt;
  logic [15:0] w_a, w_b, w_d;
  logic [15:0] w_s6, w_s9;
  logic [15:0] w_sum;
  logic [15:0] w_pc_inc;
  logic [DMEM_AW-1:0] w_daddr;
  logic        w_run;
  logic        w_wb;
  logic        w_dwe;
  logic        w_halt;
  logic [15:0] w_val;
  logic [15:0] w_pc_nxt;
  logic        w_unused;

  assign w_ins    = r_imem[r_pc[IMEM_AW-1:0]];
  assign w_op     = w_ins[15:12];
  assign w_rd     = w_ins[11:9];
  assign w_rs     = w_ins[8:6];
  assign w_rt     = w_ins[5:3];
  // R0 is hardwired to zero on read
  assign w_a      = (w_rs == 3'd0) ? 16'h0 : r_rf[w_rs];
  assign w_b      = (w_rt == 3'd0) ? 16'h0 : r_rf[w_rt];
  assign w_d      = (w_rd == 3'd0) ? 16'h0 : r_rf[w_rd];
  assign w_s6     = {{10{w_ins[5]}}, w_ins[5:0]};
  assign w_s9     = {{7{w_ins[8]}}, w_ins[8:0]};
  assign w_sum    = w_a + w_s6;
  assign w_pc_inc = r_pc + 16'd1;
  assign w_daddr  = w_sum[DMEM_AW-1:0];
  assign w_run    = pc_reset & ~ld.load_instruction & ~r_halted;
  assign w_unused = ^{ld.load_address[15:IMEM_AW], w_sum[15:DMEM_AW]};

  always_comb begin
    w_wb     = 1'b0;
    w_dwe    = 1'b0;
    w_halt   = 1'b0;
    w_val    = 16'h0;
    w_pc_nxt = w_pc_inc;
    unique case (w_op)
      4'h0: w_wb = 1'b0;
      4'h1: begin w_wb = 1'b1; w_val = w_a + w_b; end
      4'h2: begin w_wb = 1'b1; w_val = w_a - w_b; end
      4'h3: begin w_wb = 1'b1; w_val = w_a & w_b; end
      4'h4: begin w_wb = 1'b1; w_val = w_a | w_b; end
      4'h5: begin w_wb = 1'b1; w_val = w_a ^ w_b; end
      4'h6: begin w_wb = 1'b1; w_val = w_a << w_b[3:0]; end
      4'h7: begin w_wb = 1'b1; w_val = w_a >> w_b[3:0]; end
      4'h8: begin w_wb = 1'b1; w_val = w_sum; end
      4'h9: begin w_wb = 1'b1; w_val = w_s9; end
      4'hA: begin w_wb = 1'b1; w_val = {w_ins[7:0], 8'h00}; end
      4'hB: begin w_wb = 1'b1; w_val = r_dmem[w_daddr]; end
      4'hC: w_dwe = w_run;
      4'hD: if (w_d == w_a) w_pc_nxt = w_pc_inc + w_s6;
      4'hE: w_pc_nxt = {4'b0, w_ins[11:0]};
      4'hF: begin w_halt = 1'b1; w_pc_nxt = r_pc; end
      default: w_wb = 1'b0;
    endcase
  end

  // Memories are not reset; imem loads even while the core is held in reset
  always_ff @(posedge clk) begin
    if (ld.load_instruction)
      r_imem[ld.load_address[IMEM_AW-1:0]] <= ld.instruction_in;
  end

  always_ff @(posedge clk) begin
    if (w_dwe) r_dmem[w_daddr] <= w_d;
  end

  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      r_pc     <= 16'h0;
      r_result <= 16'h0;
      r_halted <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0;
    end else if (w_run) begin
      r_pc <= w_pc_nxt;
      if (w_halt) r_halted <= 1'b1;
      if (w_wb) begin
        r_result <= w_val;
        if (w_rd != 3'd0) r_rf[w_rd] <= w_val;
      end
    end
  end

  assign result_reg = r_result;
`ifdef CPU16_PC_OUT_EN
  assign pc_out = r_pc;
  assign halted = r_halted;
`endif

endmodule

// File: tb/tb_cpu_16bit_core.sv
// Bench for cpu_16bit_core: directed programs plus random programs
// compared cycle by cycle against an instruction-level model.
module tb_cpu_16bit_core;

  logic        clk = 1'b0;
  logic        pc_reset = 1'b0;
  logic [15:0] result_reg;
`ifdef CPU16_PC_OUT_EN
  logic [15:0] pc_out;
  logic        halted;
`endif

  cpu_16bit_core_if lif ();

  cpu_16bit_core dut (
    .clk        (clk),
    .pc_reset   (pc_reset),
    .ld         (lif.slave),
    .result_reg (result_reg)
`ifdef CPU16_PC_OUT_EN
    ,
    .pc_out     (pc_out),
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_rf [8];
  logic [15:0] m_pc;
  logic [15:0] m_res;
  bit          m_halt;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 16'h0;
    m_res = 16'h0;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
  endtask

  // One instruction of the ISA, as the programmer sees it
  task automatic m_exec();
    logic [15:0] ins, a, b, d, s6, s9, v, ea, nxt;
    bit wb;
    ins = m_imem[m_pc[7:0]];
    a = m_rf[ins[8:6]];
    b = m_rf[ins[5:3]];
    d = m_rf[ins[11:9]];
    s6 = {{10{ins[5]}}, ins[5:0]};
    s9 = {{7{ins[8]}}, ins[8:0]};
    ea = a + s6;
    v = 16'h0;
    wb = 1'b1;
    nxt = m_pc + 16'd1;
    case (ins[15:12])
      4'h0: wb = 1'b0;
      4'h1: v = a + b;
      4'h2: v = a - b;
      4'h3: v = a & b;
      4'h4: v = a | b;
      4'h5: v = a ^ b;
      4'h6: v = a << b[3:0];
      4'h7: v = a >> b[3:0];
      4'h8: v = ea;
      4'h9: v = s9;
      4'hA: v = {ins[7:0], 8'h00};
      4'hB: v = m_dmem[ea[7:0]];
      4'hC: begin wb = 1'b0; m_dmem[ea[7:0]] = d; end
      4'hD: begin wb = 1'b0; if (d == a) nxt = m_pc + 16'd1 + s6; end
      4'hE: begin wb = 1'b0; nxt = {4'b0, ins[11:0]}; end
      default: begin wb = 1'b0; m_halt = 1'b1; nxt = m_pc; end
    endcase
    m_pc = nxt;
    if (wb) begin
      if (ins[11:9] != 3'd0) m_rf[ins[11:9]] = v;
      m_res = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (lif.load_instruction)
      m_imem[lif.load_address[7:0]] = lif.instruction_in;
    else if (pc_reset && !m_halt)
      m_exec();
    #1;
    chk("model_result", result_reg, m_res);
`ifdef CPU16_PC_OUT_EN
    chk("model_pc", pc_out, m_pc);
    chk("model_halted", {15'h0, halted}, {15'h0, m_halt});
`endif
  endtask

  task automatic do_reset();
    pc_reset = 1'b0;
    m_reset();
    #1;
    chk("async_reset", result_reg, 16'h0);
  endtask

  task automatic load(logic [15:0] addr, logic [15:0] word);
    lif.load_instruction = 1'b1;
    lif.load_address = addr;
    lif.instruction_in = word;
    step();
    lif.load_instruction = 1'b0;
  endtask

  task automatic run_expect(string tag, logic [15:0] exp[$]);
    foreach (exp[i]) begin
      step();
      chk(tag, result_reg, exp[i]);
    end
  endtask

  logic [15:0] init_prog [7] = '{16'h9200, 16'hA401, 16'hC040,
                                 16'h8241, 16'hD281, 16'hE002, 16'hF000};
  logic [15:0] w;

  initial begin
    lif.load_instruction = 1'b0;
    lif.load_address = 16'h0;
    lif.instruction_in = 16'h0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 16'h0;
    m_reset();
    #1;
    chk("reset_state", result_reg, 16'h0);

    // Fill all of imem, then clear all of dmem with a loop program
    for (int i = 0; i < 256; i++)
      load(16'(i), (i < 7) ? init_prog[i] : 16'h0000);
    pc_reset = 1'b1;
    for (int k = 0; k < 2000 && !m_halt; k++) step();
    step();
    chk("init_done", result_reg, 16'h0100);

    // LI/LI/ADD/HALT, loaded under reset
    do_reset();
    load(0, 16'h9205); load(1, 16'h9403);
    load(2, 16'h1650); load(3, 16'hF000);
    pc_reset = 1'b1;
    run_expect("add_seq", '{16'h5, 16'h3, 16'h8, 16'h8, 16'h8});

    // Reset mid-run, then restart from PC 0
    do_reset();
    pc_reset = 1'b1;
    run_expect("pre_abort", '{16'h5, 16'h3});
    do_reset();
    pc_reset = 1'b1;
    run_expect("restart", '{16'h5, 16'h3, 16'h8});

    // Stall for three load cycles mid-run
    do_reset();
    pc_reset = 1'b1;
    run_expect("pre_stall", '{16'h5});
    for (int i = 0; i < 3; i++) begin
      load(16'(200 + i), 16'($urandom));
      chk("stall_hold", result_reg, 16'h5);
    end
    run_expect("post_stall", '{16'h3, 16'h8, 16'h8});

    // SUB both ways
    do_reset();
    load(0, 16'h9205); load(1, 16'h9403);
    load(2, 16'h2850); load(3, 16'hF000);
    pc_reset = 1'b1;
    run_expect("sub_pos", '{16'h5, 16'h3, 16'h2, 16'h2});
    do_reset();
    load(0, 16'h9203); load(1, 16'h9405);
    pc_reset = 1'b1;
    run_expect("sub_neg", '{16'h3, 16'h5, 16'hFFFE, 16'hFFFE});

    // Store then load back
    do_reset();
    load(0, 16'h927F); load(1, 16'hC204);
    load(2, 16'hBA04); load(3, 16'hF000);
    pc_reset = 1'b1;
    run_expect("sw_lw", '{16'h7F, 16'h7F, 16'h7F, 16'h7F});

    // BEQ taken skips LI R3,7; BEQ not taken falls through
    do_reset();
    load(0, 16'h9201); load(1, 16'h9401); load(2, 16'hD281);
    load(3, 16'h9607); load(4, 16'h9809); load(5, 16'hD301);
    load(6, 16'h9A0A); load(7, 16'hF000);
    pc_reset = 1'b1;
    run_expect("beq", '{16'h1, 16'h1, 16'h1, 16'h9, 16'h9,
                        16'hA, 16'hA});

    // Random programs with random stalls and reloads
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0)
          w[15:12] = 4'h1;
        load(16'(i), w);
      end
      pc_reset = 1'b1;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          load(16'($urandom), 16'($urandom));
        end else begin
          step();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
